tug_referee: RTL and testbench
==============================

# tug_referee

Game controller for the tug-of-war datapath. It consumes the two one-cycle press pulses produced by the per-player edge detectors and arbitrates simultaneous presses. It moves the rope light along the LED bar, awards points, holds a pause between rounds and declares the match winner. It sits between the edge-detector stage and the LED/HEX display drivers.

## Interface
- NUM_LEDS, 9: length of the LED bar. Odd, ≥3. Index NUM_LEDS-1 is the left player's end; index 0 is the right player's end.
- WIN_SCORE, 3: points needed to win the match. Range 1..7.
- HOLD_CYCLES, 4: length of the post-point pause in clk cycles. ≥1.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- left_pulse  in  1  one-cycle pulse, left player press (edge-detected).
- right_pulse  in  1  one-cycle pulse, right player press (edge-detected).
- leds  out  NUM_LEDS  rope light: one-hot in PLAY, all zero otherwise.
- left_score  out  3  left points, 0..WIN_SCORE.
- right_score  out  3  right points, 0..WIN_SCORE.
- point  out  1  one-cycle strobe in the cycle after a point is awarded.
- game_over  out  1  high while in GAMEOVER.
- winner  out  2  00 none, 01 left, 10 right; valid while game_over is high.

## Operation
- State machine has three states: PLAY, POINT and GAMEOVER.
- Registered state:
  - state
  - pos (width $clog2(NUM_LEDS)); CENTER = NUM_LEDS/2
  - hold counter
  - both scores
  - point flag
  - winner
- On reset:
  - state=PLAY, pos=CENTER
  - scores=0, point=0, winner=00
  - leds=one-hot CENTER, game_over=0
- PLAY, evaluated each edge:
  - Neither pulse, or both pulses in the same cycle: no change. A tie cancels.
  - left only, pos<NUM_LEDS-1: pos+1.
  - left only, pos==NUM_LEDS-1: left scores.
  - right only, pos>0: pos-1.
  - right only, pos==0: right scores.
- Scoring event:
  - The scorer's score increments and point=1 for exactly one cycle.
  - If the new score == WIN_SCORE: go to GAMEOVER and set winner.
  - Otherwise: go to POINT and load hold counter = HOLD_CYCLES-1.
- POINT:
  - leds=0 and all pulses are ignored.
  - The counter decrements each cycle. At 0, the next edge sets pos=CENTER and goes to PLAY.
  - The result is exactly HOLD_CYCLES cycles in POINT.
- GAMEOVER:
  - leds=0; scores and winner are frozen; pulses are ignored.
  - Only reset exits this state.
- Scores never exceed WIN_SCORE and never wrap.
- Reset mid-round or mid-hold: immediate return to reset values, with no residual point strobe.

## Timing
- A pulse sampled at edge N is reflected in pos, leds, scores and point after edge N. That is one cycle of latency; there are no further pipeline stages.
- leds, game_over and winner are combinational decodes of registered state and pos, with no extra delay.
- point is registered; it is high for the single cycle following the scoring edge.
- A scoring edge and the state transition occur together. The first POINT/GAMEOVER cycle is the same cycle point is high.
- Input pulses arriving in POINT or GAMEOVER are dropped, not queued.

## Structure
- Package tug_pkg:
  - state enum {PLAY, POINT, GAMEOVER}
  - winner enum {NONE=2'b00, LEFT=2'b01, RIGHT=2'b10}
  - score width constant (3)
- Sub-module tug_score_counter, instantiated once per player:
  - inc input
  - saturates at a WIN_SCORE parameter
  - asynchronous reset
  - outputs count and a reached flag, which drives the GAMEOVER decision
- Everything else lives in tug_referee: position register, FSM and hold counter.

## Test plan
All scenarios use NUM_LEDS=9, WIN_SCORE=3, HOLD_CYCLES=4.
- Reset, including with left_pulse held high:
  - leds=9'b000010000, both scores 0, winner=00, point=0, game_over=0.
- Movement:
  - 4 left pulses on separate cycles: leds=9'b100000000.
  - 1 right pulse: leds=9'b010000000.
  - left+right pulses in the same cycle: leds unchanged.
- Left point:
  - With pos=8, one left pulse: left_score=1, point high one cycle, leds=0 for 4 cycles, then leds=9'b000010000.
  - Pulses sent during the hold have no effect.
- Right edge boundary:
  - With pos=0, a right pulse scores; right_score=1.
  - A left pulse at pos=0 moves to pos=1 and does not score.
- Match win:
  - Drive the right player to 3 points: game_over=1, winner=10, right_score=3, leds=0.
  - Further pulses change nothing; reset restores the reset state.
- Reset during POINT:
  - Assert reset two cycles into the hold: outputs return to reset values asynchronously.
  - PLAY resumes after deassertion, with no point strobe.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war referee.
package tug_pkg;

   typedef enum logic [1:0] {
      PLAY,
      POINT,
      GAMEOVER
   } state_e;

   typedef enum logic [1:0] {
      NONE  = 2'b00,
      LEFT  = 2'b01,
      RIGHT = 2'b10
   } winner_e;

   localparam int unsigned ScoreWidth = 3;

endpackage

// File: rtl/tug_score_counter.sv
// Per-player saturating score counter with a match-point indicator.
module tug_score_counter
   import tug_pkg::*;
#(
   parameter int unsigned WIN_SCORE = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inc,
   output logic [ScoreWidth-1:0] count,
   output logic                  reached
);

   localparam logic [ScoreWidth-1:0] Win = ScoreWidth'(WIN_SCORE);

   logic [ScoreWidth-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != Win)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Reflects the count after this edge so the referee can decide GAMEOVER
   // in the same cycle the winning point is scored.
   assign reached = (count_d == Win);
   assign count   = count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/tug_referee.sv
// Tug-of-war game controller: rope position, scoring, post-point hold and
// match-win detection.
module tug_referee
   import tug_pkg::*;
#(
   parameter int unsigned NUM_LEDS    = 9,
   parameter int unsigned WIN_SCORE   = 3,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  left_pulse,
   input  logic                  right_pulse,
   output logic [NUM_LEDS-1:0]   leds,
   output logic [ScoreWidth-1:0] left_score,
   output logic [ScoreWidth-1:0] right_score,
   output logic                  point,
   output logic                  game_over,
   output logic [1:0]            winner
);

   localparam int unsigned PosW  = $clog2(NUM_LEDS);
   localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [PosW-1:0]     PosCenter = PosW'(NUM_LEDS / 2);
   localparam logic [PosW-1:0]     PosMax    = PosW'(NUM_LEDS - 1);
   localparam logic [HoldW-1:0]    HoldLoad  = HoldW'(HOLD_CYCLES - 1);
   localparam logic [NUM_LEDS-1:0] OneLed    = NUM_LEDS'(1);

   state_e           state_q, state_d;
   logic [PosW-1:0]  pos_q, pos_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic             point_q, point_d;
   winner_e          winner_q, winner_d;

   logic in_play, left_only, right_only;
   logic left_inc, right_inc;
   logic left_reached, right_reached;

   // A simultaneous press from both players cancels out.
   assign in_play    = (state_q == PLAY);
   assign left_only  = in_play && left_pulse && !right_pulse;
   assign right_only = in_play && right_pulse && !left_pulse;
   assign left_inc   = left_only && (pos_q == PosMax);
   assign right_inc  = right_only && (pos_q == '0);

   tug_score_counter #(
      .WIN_SCORE (WIN_SCORE)
   ) u_left_score (
      .clk     (clk),
      .reset   (reset),
      .inc     (left_inc),
      .count   (left_score),
      .reached (left_reached)
   );

   tug_score_counter #(
      .WIN_SCORE (WIN_SCORE)
   ) u_right_score (
      .clk     (clk),
      .reset   (reset),
      .inc     (right_inc),
      .count   (right_score),
      .reached (right_reached)
   );

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      hold_d   = hold_q;
      point_d  = 1'b0;
      winner_d = winner_q;

      unique case (state_q)
         PLAY: begin
            if (left_inc || right_inc) begin
               point_d = 1'b1;
               if ((left_inc && left_reached) || (right_inc && right_reached)) begin
                  state_d  = GAMEOVER;
                  winner_d = left_inc ? LEFT : RIGHT;
               end else begin
                  state_d = POINT;
                  hold_d  = HoldLoad;
               end
            end else if (left_only) begin
               pos_d = pos_q + 1'b1;
            end else if (right_only) begin
               pos_d = pos_q - 1'b1;
            end
         end
         POINT: begin
            if (hold_q == '0) begin
               state_d = PLAY;
               pos_d   = PosCenter;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         GAMEOVER: begin
         end
         default: begin
            state_d = PLAY;
            pos_d   = PosCenter;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= PLAY;
         pos_q    <= PosCenter;
         hold_q   <= '0;
         point_q  <= 1'b0;
         winner_q <= NONE;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         hold_q   <= hold_d;
         point_q  <= point_d;
         winner_q <= winner_d;
      end
   end

   assign leds      = in_play ? (OneLed << pos_q) : '0;
   assign game_over = (state_q == GAMEOVER);
   assign winner    = winner_q;
   assign point     = point_q;

endmodule

// File: tb/tb_tug_referee.sv
// Self-checking bench for tug_referee: game-level model plus directed scenarios.
module tb_tug_referee;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       left_pulse = 1'b0;
   logic       right_pulse = 1'b0;
   logic [8:0] leds;
   logic [2:0] left_score, right_score;
   logic       point, game_over;
   logic [1:0] winner;

   int compared = 0;
   int mismatched = 0;
   bit check_en = 1'b0;

   // Game-level model
   int m_pos, m_ls, m_rs, m_hold, m_win;
   bit m_point, m_over;

   tug_referee #(
      .NUM_LEDS    (9),
      .WIN_SCORE   (3),
      .HOLD_CYCLES (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .left_pulse  (left_pulse),
      .right_pulse (right_pulse),
      .leds        (leds),
      .left_score  (left_score),
      .right_score (right_score),
      .point       (point),
      .game_over   (game_over),
      .winner      (winner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] model_leds();
      logic [8:0] v;
      v = '0;
      if (!m_over && m_hold == 0) v[m_pos] = 1'b1;
      return v;
   endfunction

   task automatic model_score(input bit is_left);
      m_point = 1'b1;
      if (is_left) m_ls++; else m_rs++;
      if ((is_left ? m_ls : m_rs) == 3) begin
         m_over = 1'b1;
         m_win  = is_left ? 1 : 2;
      end else begin
         m_hold = 4;
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pos = 4; m_ls = 0; m_rs = 0; m_hold = 0; m_win = 0;
         m_point = 1'b0; m_over = 1'b0;
      end else begin
         m_point = 1'b0;
         if (m_over) begin
         end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_pos = 4;
         end else if (left_pulse && !right_pulse) begin
            if (m_pos == 8) model_score(1'b1); else m_pos++;
         end else if (right_pulse && !left_pulse) begin
            if (m_pos == 0) model_score(1'b0); else m_pos--;
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("leds", 32'(leds), 32'(model_leds()));
         chk("left_score", 32'(left_score), 32'(m_ls));
         chk("right_score", 32'(right_score), 32'(m_rs));
         chk("point", 32'(point), 32'(m_point));
         chk("game_over", 32'(game_over), 32'(m_over));
         chk("winner", 32'(winner), 32'(m_win));
      end
   end

   task automatic pulse(input bit l, input bit r);
      @(posedge clk); #1;
      left_pulse = l; right_pulse = r;
      @(posedge clk); #1;
      left_pulse = 1'b0; right_pulse = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_leds"}, 32'(leds), 32'h010);
      chk({tag, "_lscore"}, 32'(left_score), 32'd0);
      chk({tag, "_rscore"}, 32'(right_score), 32'd0);
      chk({tag, "_point"}, 32'(point), 32'd0);
      chk({tag, "_game_over"}, 32'(game_over), 32'd0);
      chk({tag, "_winner"}, 32'(winner), 32'd0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with left held high
      left_pulse = 1'b1;
      #1 check_en = 1'b1;
      idle(2);
      check_reset_values("reset");
      reset = 1'b0; left_pulse = 1'b0;
      idle(1);
      check_reset_values("post_reset");

      // Movement
      repeat (4) pulse(1'b1, 1'b0);
      chk("move_left4", 32'(leds), 32'h100);
      chk("model_left4", 32'(model_leds()), 32'h100);
      pulse(1'b0, 1'b1);
      chk("move_right1", 32'(leds), 32'h080);
      pulse(1'b1, 1'b1);
      chk("tie_cancel", 32'(leds), 32'h080);

      // Left point at pos 8, pulses during the hold are dropped
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      chk("lpoint_score", 32'(left_score), 32'd1);
      chk("lpoint_strobe", 32'(point), 32'd1);
      chk("lpoint_leds1", 32'(leds), 32'h000);
      left_pulse = 1'b1;
      idle(1);
      chk("lpoint_strobe_off", 32'(point), 32'd0);
      chk("lpoint_leds2", 32'(leds), 32'h000);
      left_pulse = 1'b0; right_pulse = 1'b1;
      idle(1);
      chk("lpoint_leds3", 32'(leds), 32'h000);
      right_pulse = 1'b0;
      idle(1);
      chk("lpoint_leds4", 32'(leds), 32'h000);
      idle(1);
      chk("lpoint_resume", 32'(leds), 32'h010);
      chk("lpoint_score_kept", 32'(left_score), 32'd1);

      // Right edge boundary
      repeat (4) pulse(1'b0, 1'b1);
      chk("at_pos0", 32'(leds), 32'h001);
      pulse(1'b1, 1'b0);
      chk("left_at_pos0", 32'(leds), 32'h002);
      chk("left_at_pos0_noscore", 32'(left_score), 32'd1);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      chk("rpoint_score", 32'(right_score), 32'd1);
      chk("rpoint_strobe", 32'(point), 32'd1);
      idle(4);

      // Right player wins the match
      for (int p = 0; p < 2; p++) begin
         repeat (5) pulse(1'b0, 1'b1);
         if (p == 0) idle(4);
      end
      chk("win_game_over", 32'(game_over), 32'd1);
      chk("win_winner", 32'(winner), 32'd2);
      chk("win_rscore", 32'(right_score), 32'd3);
      chk("win_leds", 32'(leds), 32'h000);
      chk("win_strobe", 32'(point), 32'd1);
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      chk("frozen_rscore", 32'(right_score), 32'd3);
      chk("frozen_winner", 32'(winner), 32'd2);
      chk("frozen_point", 32'(point), 32'd0);
      reset = 1'b1;
      #1 check_reset_values("win_reset");
      idle(1);
      reset = 1'b0;
      idle(1);

      // Reset two cycles into a hold
      repeat (5) pulse(1'b1, 1'b0);
      chk("hold2_strobe", 32'(point), 32'd1);
      idle(1);
      #2 reset = 1'b1;
      #1 check_reset_values("hold_reset");
      idle(1);
      reset = 1'b0;
      idle(2);
      chk("after_reset_point", 32'(point), 32'd0);
      pulse(1'b1, 1'b0);
      chk("after_reset_move", 32'(leds), 32'h020);
      idle(2);

      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
